// File: rtl/vga_text_engine.sv
// vga_text_engine: character VRAM with CPU write/read-back plus 8x8-cell text scan-out and VGA sync.
// Latency: rd_data 1 clk; pixel (x,y) registered on the pix_ce where hcnt==x, vcnt==y. No backpressure.
// Optional blinking underline cursor when CURSOR_EN is defined (adds cur_addr/cur_on and BLINK_FRAMES).
module vga_text_engine #(
    parameter int COLS   = 80,
    parameter int ROWS   = 60,
    parameter int ADDR_W = 13,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
`ifdef CURSOR_EN
    ,
    parameter int BLINK_FRAMES = 32
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_ce,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic [10:0]       font_addr,
    input  logic [7:0]        font_data,
`ifdef CURSOR_EN
    input  logic [ADDR_W-1:0] cur_addr,
    input  logic              cur_on,
`endif
    output logic              hsync,
    output logic              vsync,
    output logic              rgb,
    output logic              vblank,
    output logic              frame_start
);
    localparam int H_VIS = 8 * COLS;
    localparam int V_VIS = 8 * ROWS;
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int DEPTH = COLS * ROWS;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);

    localparam logic [HW-1:0] H_VIS_C  = HW'(H_VIS);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_PRE    = HW'(H_TOT - 2);
    localparam logic [HW-1:0] H_CELL_L = HW'(H_VIS - 8);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_VIS + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_VIS + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_VIS_C  = VW'(V_VIS);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_VIS + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_VIS + V_FP + V_SYNC);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] COLS_C  = ADDR_W'(COLS);

    typedef enum logic [1:0] {IDLE, VRD, FRD, LATCH} fetch_state_t;

    logic [7:0]        mem [DEPTH];
    logic [HW-1:0]     hcnt;
    logic [VW-1:0]     vcnt;
    logic [ADDR_W-1:0] line_base;
    fetch_state_t      state;
    logic [ADDR_W-1:0] fetch_addr;
    logic [2:0]        fetch_line;
    logic [7:0]        fetch_char;
    logic [7:0]        next_bits;
    logic [7:0]        shifter;
    logic [7:0]        invert;

    logic [VW-1:0]     vnext;
    logic [ADDR_W-1:0] base_next;
    logic [ADDR_W-1:0] col_next;
    logic              start_cell;
    logic              start_pre;

    always_ff @(posedge clk) begin
        if (wr_en && ({1'b0, wr_addr} < DEPTH_C)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data <= '0;
        end else if ({1'b0, rd_addr} < DEPTH_C) begin
            rd_data <= mem[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

    // Row base advances by COLS after the 8th scanline of each text row: no multiplier needed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hcnt      <= '0;
            vcnt      <= '0;
            line_base <= '0;
        end else if (pix_ce) begin
            if (hcnt == H_LAST) begin
                hcnt <= '0;
                if (vcnt == V_LAST) begin
                    vcnt      <= '0;
                    line_base <= '0;
                end else begin
                    vcnt <= vcnt + 1'b1;
                    if (vcnt[2:0] == 3'd7) begin
                        line_base <= line_base + COLS_C;
                    end
                end
            end else begin
                hcnt <= hcnt + 1'b1;
            end
        end
    end

    // Cell 0 of the next line is prefetched two pixels before the line ends, so it
    // needs the row base and scanline the counters will hold after the wrap.
    always_comb begin
        vnext      = (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        base_next  = (vcnt == V_LAST) ? '0 :
                     ((vcnt[2:0] == 3'd7) ? line_base + COLS_C : line_base);
        col_next   = ADDR_W'(hcnt[HW-1:3]) + 1'b1;
        start_cell = pix_ce && (hcnt[2:0] == 3'd6) && (hcnt < H_CELL_L) && (vcnt < V_VIS_C);
        start_pre  = pix_ce && (hcnt == H_PRE) && (vnext < V_VIS_C);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            fetch_addr <= '0;
            fetch_line <= '0;
            fetch_char <= '0;
            next_bits  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_cell) begin
                        fetch_addr <= line_base + col_next;
                        fetch_line <= vcnt[2:0];
                        state      <= VRD;
                    end else if (start_pre) begin
                        fetch_addr <= base_next;
                        fetch_line <= vnext[2:0];
                        state      <= VRD;
                    end
                end
                VRD: begin
                    fetch_char <= ({1'b0, fetch_addr} < DEPTH_C) ? mem[fetch_addr] : 8'h00;
                    state      <= FRD;
                end
                FRD: begin
                    state <= LATCH;
                end
                LATCH: begin
                    next_bits <= font_data ^ invert;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign font_addr = {fetch_char, fetch_line};

`ifdef CURSOR_EN
    localparam int BW = $clog2(BLINK_FRAMES + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    always_ff @(posedge clk) begin
        if (!rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (pix_ce && (hcnt == H_LAST) && (vcnt == V_LAST)) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign invert = {8{cur_on && blink_phase && (fetch_addr == cur_addr) && (fetch_line[2:1] == 2'b11)}};
`else
    assign invert = 8'h00;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            rgb         <= 1'b0;
            vblank      <= 1'b0;
            frame_start <= 1'b0;
            shifter     <= '0;
        end else begin
            frame_start <= pix_ce && (hcnt == '0) && (vcnt == '0);
            if (pix_ce) begin
                hsync  <= !((hcnt >= HS_BEG) && (hcnt < HS_END));
                vsync  <= !((vcnt >= VS_BEG) && (vcnt < VS_END));
                vblank <= (vcnt >= V_VIS_C);
                rgb    <= (hcnt < H_VIS_C) && (vcnt < V_VIS_C) && shifter[7];
                if ((hcnt[2:0] == 3'd7) || (hcnt == H_LAST)) begin
                    shifter <= next_bits;
                end else begin
                    shifter <= {shifter[6:0], 1'b0};
                end
            end
        end
    end
endmodule

// File: tb/tb_vga_text_engine.sv
// Self-checking bench for vga_text_engine on a shrunken 4x3-cell screen with random pix_ce spacing.
module tb_vga_text_engine;
    localparam int COLS = 4, ROWS = 3, ADDR_W = 4;
    localparam int H_FP = 2, H_SYNC = 3, H_BP = 3, V_FP = 2, V_SYNC = 2, V_BP = 2;
    localparam int H_VIS = 8 * COLS, V_VIS = 8 * ROWS;
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int FRAME = H_TOT * V_TOT;
    localparam int DEPTH = COLS * ROWS;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              pix_ce = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [7:0]        wr_data = '0;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [7:0]        rd_data;
    logic [10:0]       font_addr;
    logic [7:0]        font_data = '0;
    logic              hsync, vsync, rgb, vblank, frame_start;
`ifdef CURSOR_EN
    logic [ADDR_W-1:0] cur_addr = '0;
    logic              cur_on = 1'b0;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vga_text_engine #(
        .COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W),
        .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) dut (
        .clk(clk), .rst(rst), .pix_ce(pix_ce),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .font_addr(font_addr), .font_data(font_data),
`ifdef CURSOR_EN
        .cur_addr(cur_addr), .cur_on(cur_on),
`endif
        .hsync(hsync), .vsync(vsync), .rgb(rgb), .vblank(vblank), .frame_start(frame_start)
    );

    function automatic logic [7:0] font_fn(input logic [7:0] c, input logic [2:0] l);
        if (c == 8'h00) return 8'h00;
        if (c == 8'hFF) return 8'hFF;
        if (c == 8'h41 && l == 3'd0) return 8'h81;
        return (c * 8'd37) ^ ({5'd0, l} * 8'd29) ^ 8'h5A;
    endfunction

    always @(posedge clk) font_data <= font_fn(font_addr[10:3], font_addr[2:0]);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Reference: pixel index since reset -> (x, y, frame); screen image from VRAM copy and font.
    logic [7:0] mv [1 << ADDR_W];
    int   k = 0, cur_x = 0, cur_y = 0, cur_f = 0;
    logic new_pix = 1'b0;
    logic exp_hs = 1'b1, exp_vs = 1'b1, exp_rgb = 1'b0, exp_vb = 1'b0, exp_fs = 1'b0;
    logic [7:0] exp_rd = 8'h00;

    function automatic logic pixel(input int x, input int y, input int f);
        logic [7:0] g;
        if (x >= H_VIS || y >= V_VIS) return 1'b0;
        if (f == 0 && y == 0 && x < 8) return 1'b0;
        g = font_fn(mv[(y / 8) * COLS + x / 8], 3'(y % 8));
        return g[7 - (x % 8)];
    endfunction

    always @(posedge clk) begin
        new_pix = 1'b0;
        if (!rst) begin
            k = 0; cur_x = 0; cur_y = 0; cur_f = 0;
            exp_hs = 1'b1; exp_vs = 1'b1; exp_rgb = 1'b0; exp_vb = 1'b0; exp_fs = 1'b0; exp_rd = 8'h00;
        end else begin
            exp_rd = (int'(rd_addr) < DEPTH) ? mv[rd_addr] : 8'h00;
            exp_fs = 1'b0;
            if (pix_ce) begin
                cur_x = k % H_TOT;
                cur_y = (k / H_TOT) % V_TOT;
                cur_f = k / FRAME;
                exp_hs = !(cur_x >= H_VIS + H_FP && cur_x < H_VIS + H_FP + H_SYNC);
                exp_vs = !(cur_y >= V_VIS + V_FP && cur_y < V_VIS + V_FP + V_SYNC);
                exp_vb = (cur_y >= V_VIS);
                exp_fs = (cur_x == 0 && cur_y == 0);
                exp_rgb = pixel(cur_x, cur_y, cur_f);
                new_pix = 1'b1;
                k++;
            end
        end
        if (wr_en && int'(wr_addr) < DEPTH) mv[wr_addr] = wr_data;
    end

    logic cap_en = 1'b0;
    logic cap [V_VIS][H_TOT];

    always @(negedge clk) begin
        chk("hsync", 32'(hsync), 32'(exp_hs));
        chk("vsync", 32'(vsync), 32'(exp_vs));
        chk("vblank", 32'(vblank), 32'(exp_vb));
        chk("frame_start", 32'(frame_start), 32'(exp_fs));
        chk("rgb", 32'(rgb), 32'(exp_rgb));
        chk("rd_data", 32'(rd_data), 32'(exp_rd));
        if (cap_en && new_pix && cur_f == 1 && cur_y < V_VIS) cap[cur_y][cur_x] = rgb;
    end

    // Pixel enable: first pulse 4 clks after reset release, then random spacing of 4..6 clks.
    initial begin
        int gap_cnt, gap;
        gap_cnt = 0; gap = 4;
        forever begin
            @(posedge clk); #2;
            if (!rst) begin
                gap_cnt = 0; gap = 4; pix_ce = 1'b0;
            end else begin
                gap_cnt++;
                if (gap_cnt >= gap) begin
                    pix_ce = 1'b1; gap_cnt = 0; gap = $urandom_range(4, 6);
                end else begin
                    pix_ce = 1'b0;
                end
            end
        end
    end

    task automatic step;
        @(posedge clk); #1;
    endtask

    task automatic wait_y(input int lo, input int hi, input string nm);
        int t;
        for (t = 0; t < 20000 && !(cur_y >= lo && cur_y <= hi); t++) step();
        if (t == 20000) begin
            n_cmp++; n_fail++;
            $display("FAIL %s: timed out waiting for line %0d..%0d", nm, lo, hi);
        end
    endtask

    task automatic random_run(input int cycles);
        for (int n = 0; n < cycles; n++) begin
            step();
            rd_addr = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
            if (cur_y >= V_VIS && cur_y <= V_TOT - 3 && $urandom_range(0, 3) == 0) begin
                wr_en   = 1'b1;
                wr_addr = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
                case ($urandom_range(0, 3))
                    0: wr_data = 8'h00;
                    1: wr_data = 8'h41;
                    2: wr_data = 8'hFF;
                    default: wr_data = 8'($urandom);
                endcase
            end else begin
                wr_en = 1'b0;
            end
        end
        step();
        wr_en = 1'b0;
    endtask

    initial begin
        int fs_at, t;
        for (int a = 0; a < DEPTH; a++) begin
            step();
            wr_en = 1'b1; wr_addr = ADDR_W'(a);
            wr_data = (a < 2) ? 8'h41 : ((a == DEPTH - 1) ? 8'hFF : 8'h00);
        end
        step();
        wr_en = 1'b0;
        chk("reset_hsync", 32'(hsync), 32'd1);
        chk("reset_vsync", 32'(vsync), 32'd1);
        chk("reset_rgb", 32'(rgb), 32'd0);
        chk("reset_rd_data", 32'(rd_data), 32'd0);
        chk("reset_frame_start", 32'(frame_start), 32'd0);

        rst = 1'b1;
        cap_en = 1'b1;
        fs_at = 0;
        for (int i = 1; i <= 10 && fs_at == 0; i++) begin
            step();
            if (frame_start) fs_at = i;
        end
        chk("first_frame_start_delay", 32'(fs_at), 32'd4);

        for (t = 0; t < 20000 && cur_f < 2; t++) step();
        if (t == 20000) begin
            n_cmp++; n_fail++;
            $display("FAIL wait_frame2: timed out");
        end
        cap_en = 1'b0;

        chk("line0_px0", 32'(cap[0][0]), 32'd1);
        for (int x = 1; x <= 6; x++) chk("line0_px1to6", 32'(cap[0][x]), 32'd0);
        chk("line0_px7", 32'(cap[0][7]), 32'd1);
        chk("line0_px8_cell1", 32'(cap[0][8]), 32'd1);
        chk("line0_px9_cell1", 32'(cap[0][9]), 32'd0);
        for (int y = 16; y < 24; y++)
            for (int x = 0; x < H_TOT; x++)
                chk("last_cell_box", 32'(cap[y][x]), 32'(x >= 24 && x <= 31));

        wait_y(V_VIS, V_VIS, "wait_vblank_rd");
        wr_en = 1'b1; wr_addr = ADDR_W'(DEPTH - 1); wr_data = 8'h5A;
        step(); wr_en = 1'b0; rd_addr = ADDR_W'(DEPTH - 1);
        step(); chk("rd_last_addr", 32'(rd_data), 32'h5A);
        wr_en = 1'b1; wr_addr = ADDR_W'(DEPTH); wr_data = 8'hFF;
        step(); wr_en = 1'b0; rd_addr = ADDR_W'(DEPTH);
        step(); chk("rd_out_of_range", 32'(rd_data), 32'h00);
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'h22;
        step(); wr_data = 8'h11; rd_addr = 4'd5;
        step(); wr_en = 1'b0;
        chk("rd_before_write_old", 32'(rd_data), 32'h22);
        step(); chk("rd_after_write_new", 32'(rd_data), 32'h11);

        random_run(12000);

        wait_y(10, 10, "wait_midframe");
        rst = 1'b0; wr_en = 1'b0;
        step(); step();
        rst = 1'b1;
        random_run(9000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
